// File: rtl/gb_cpu_interrupt_ctrl.sv
// GameBoy interrupt controller: IF/IE/IME state, HALT handling and the
// 5-M-cycle interrupt dispatch sequence that replaces an opcode fetch.
module gb_cpu_interrupt_ctrl #(
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter logic [7:0] VECTOR_STRIDE = 8'h08
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] irq_req,
    input  logic       if_wr_en,
    input  logic [4:0] if_wr_data,
    input  logic       ie_wr_en,
    input  logic [7:0] ie_wr_data,
    output logic [7:0] if_rd_data,
    output logic [7:0] ie_rd_data,
    input  logic       ei_exec,
    input  logic       reti_exec,
    input  logic       di_exec,
    input  logic       halt_exec,
    input  logic       instr_boundary,
    output logic       dispatch_active,
    output logic [2:0] dispatch_step,
    output logic [7:0] vector_addr,
    output logic       halted,
    output logic       halt_bug
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_DISPATCH
    } state_t;

    localparam logic [2:0] VEC_NONE = 3'd5;

    state_t     state_q, state_d;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic       ime_q, ime_d;
    logic       ime_pending_q, ime_pending_d;
    logic [2:0] step_q, step_d;
    logic [2:0] vec_idx_q, vec_idx_d;
    logic       halt_bug_q, halt_bug_d;

    logic [4:0] pend;
    logic [2:0] pend_idx;
    logic       take_irq;
    logic [4:0] ack_mask;

    assign pend = ie_q[4:0] & if_q;

    always_comb begin
        pend_idx = VEC_NONE;
        for (int unsigned i = 0; i < 5; i++) begin
            if (pend[4 - i]) pend_idx = 3'(4 - i);
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        vec_idx_d     = vec_idx_q;
        ime_d         = ime_q;
        ime_pending_d = ime_pending_q;
        halt_bug_d    = 1'b0;
        take_irq      = 1'b0;
        ack_mask      = '0;
        ie_d          = ie_wr_en ? ie_wr_data : ie_q;

        unique case (state_q)
            ST_RUN: begin
                if (instr_boundary) begin
                    // Dispatch decision uses the pre-boundary IME so EI's successor runs.
                    ime_d         = ime_q | ime_pending_q;
                    ime_pending_d = 1'b0;
                    if (ime_q && (pend != '0)) begin
                        take_irq = 1'b1;
                        state_d  = ST_DISPATCH;
                        step_d   = '0;
                    end else if (halt_exec) begin
                        if (!ime_q && (pend != '0)) halt_bug_d = 1'b1;
                        else                        state_d    = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (pend != '0) begin
                    if (ime_q) begin
                        take_irq = 1'b1;
                        state_d  = ST_DISPATCH;
                        step_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DISPATCH: begin
                step_d = step_q + 3'd1;
                if (step_q == 3'd3) vec_idx_d = pend_idx;
                if (step_q == 3'd4) begin
                    step_d  = '0;
                    state_d = ST_RUN;
                    if (vec_idx_q < VEC_NONE) ack_mask = 5'b00001 << vec_idx_q;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (di_exec) begin
            ime_d         = 1'b0;
            ime_pending_d = 1'b0;
        end else begin
            if (reti_exec) ime_d         = 1'b1;
            if (ei_exec)   ime_pending_d = 1'b1;
        end
        if (take_irq) ime_d = 1'b0;

        if_d = ((if_wr_en ? if_wr_data : if_q) & ~ack_mask) | irq_req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            if_q          <= '0;
            ie_q          <= '0;
            ime_q         <= 1'b0;
            ime_pending_q <= 1'b0;
            step_q        <= '0;
            vec_idx_q     <= VEC_NONE;
            halt_bug_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_q          <= if_d;
            ie_q          <= ie_d;
            ime_q         <= ime_d;
            ime_pending_q <= ime_pending_d;
            step_q        <= step_d;
            vec_idx_q     <= vec_idx_d;
            halt_bug_q    <= halt_bug_d;
        end
    end

    assign if_rd_data      = {3'b111, if_q};
    assign ie_rd_data      = ie_q;
    assign dispatch_active = (state_q == ST_DISPATCH);
    assign dispatch_step   = step_q;
    assign halted          = (state_q == ST_HALT);
    assign halt_bug        = halt_bug_q;
    assign vector_addr     = (vec_idx_q >= VEC_NONE) ? 8'h00
                           : VECTOR_BASE + VECTOR_STRIDE * {5'b00000, vec_idx_q};

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_gb_cpu_interrupt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [4:0] irq_req;
    logic       if_wr_en;
    logic [4:0] if_wr_data;
    logic       ie_wr_en;
    logic [7:0] ie_wr_data;
    logic       ei_exec, reti_exec, di_exec, halt_exec, instr_boundary;
    logic [7:0] if_rd_data, ie_rd_data, vector_addr;
    logic       dispatch_active, halted, halt_bug;
    logic [2:0] dispatch_step;

    gb_cpu_interrupt_ctrl #(
        .VECTOR_BASE  (8'h40),
        .VECTOR_STRIDE(8'h08)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq_req        (irq_req),
        .if_wr_en       (if_wr_en),
        .if_wr_data     (if_wr_data),
        .ie_wr_en       (ie_wr_en),
        .ie_wr_data     (ie_wr_data),
        .if_rd_data     (if_rd_data),
        .ie_rd_data     (ie_rd_data),
        .ei_exec        (ei_exec),
        .reti_exec      (reti_exec),
        .di_exec        (di_exec),
        .halt_exec      (halt_exec),
        .instr_boundary (instr_boundary),
        .dispatch_active(dispatch_active),
        .dispatch_step  (dispatch_step),
        .vector_addr    (vector_addr),
        .halted         (halted),
        .halt_bug       (halt_bug)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = running, 1 = halted, 2 = dispatching.
    int         m_mode = 0;
    int         m_step = 0;
    int         m_vidx = 5;
    logic [4:0] m_if   = '0;
    logic [7:0] m_ie   = '0;
    bit         m_ime  = 0;
    bit         m_pen  = 0;
    bit         m_bug  = 0;

    function automatic int lowest_pending(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return 5;
    endfunction

    function automatic logic [7:0] vector_of(input int idx);
        if (idx >= 5) return 8'h00;
        return 8'((64 + 8 * idx) % 256);
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] p;
        logic [4:0] nif;
        int         nmode, nstep, nvidx;
        bit         nime, npen, nbug, take;
        if (!reset_n) begin
            m_mode = 0; m_step = 0; m_vidx = 5;
            m_if = '0; m_ie = '0; m_ime = 0; m_pen = 0; m_bug = 0;
        end else begin
            p     = m_ie[4:0] & m_if;
            nif   = if_wr_en ? if_wr_data : m_if;
            nmode = m_mode; nstep = m_step; nvidx = m_vidx;
            nime  = m_ime;  npen  = m_pen;  nbug  = 0; take = 0;
            if (m_mode == 0) begin
                if (instr_boundary) begin
                    nime = m_ime | m_pen;
                    npen = 0;
                    if (m_ime && p != 0) begin
                        take = 1; nmode = 2; nstep = 0;
                    end else if (halt_exec) begin
                        if (!m_ime && p != 0) nbug = 1;
                        else                  nmode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (p != 0) begin
                    if (m_ime) begin take = 1; nmode = 2; nstep = 0; end
                    else nmode = 0;
                end
            end else begin
                if (m_step == 3) nvidx = lowest_pending(p);
                if (m_step == 4) begin
                    if (m_vidx < 5) nif[m_vidx] = 1'b0;
                    nmode = 0; nstep = 0;
                end else begin
                    nstep = m_step + 1;
                end
            end
            if (di_exec) begin
                nime = 0; npen = 0;
            end else begin
                if (reti_exec) nime = 1;
                if (ei_exec)   npen = 1;
            end
            if (take) nime = 0;
            m_if   = nif | irq_req;
            m_ie   = ie_wr_en ? ie_wr_data : m_ie;
            m_mode = nmode; m_step = nstep; m_vidx = nvidx;
            m_ime  = nime;  m_pen  = npen;  m_bug  = nbug;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic next();
        @(negedge clk);
        chk("if_rd_data", 32'(if_rd_data), 32'({3'b111, m_if}));
        chk("ie_rd_data", 32'(ie_rd_data), 32'(m_ie));
        chk("dispatch_active", 32'(dispatch_active), 32'(m_mode == 2));
        chk("dispatch_step", 32'(dispatch_step), 32'(m_step));
        chk("halted", 32'(halted), 32'(m_mode == 1));
        chk("halt_bug", 32'(halt_bug), 32'(m_bug));
        if (m_mode == 2 && m_step == 4)
            chk("vector_addr", 32'(vector_addr), 32'(vector_of(m_vidx)));
    endtask

    task automatic clr();
        irq_req = '0; if_wr_en = 0; if_wr_data = '0; ie_wr_en = 0; ie_wr_data = '0;
        ei_exec = 0; reti_exec = 0; di_exec = 0; halt_exec = 0; instr_boundary = 0;
    endtask

    task automatic pulse();
        next();
        clr();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_rd"},  32'(if_rd_data),      32'h0E0);
        chk({tag, "_ie_rd"},  32'(ie_rd_data),      32'h000);
        chk({tag, "_active"}, 32'(dispatch_active), 32'd0);
        chk({tag, "_step"},   32'(dispatch_step),   32'd0);
        chk({tag, "_vector"}, 32'(vector_addr),     32'h00);
        chk({tag, "_halted"}, 32'(halted),          32'd0);
        chk({tag, "_bug"},    32'(halt_bug),        32'd0);
    endtask

    initial begin
        clr();
        reset_n = 0;
        pulse(); pulse();
        chk_reset_outputs("reset");
        reset_n = 1;

        // Basic dispatch on Timer
        ie_wr_en = 1; ie_wr_data = 8'h04; reti_exec = 1; pulse();
        irq_req = 5'b00100; pulse();
        chk("basic_if_set", 32'(if_rd_data), 32'h0E4);
        instr_boundary = 1; pulse();
        for (int k = 0; k < 5; k++) begin
            chk("basic_active", 32'(dispatch_active), 32'd1);
            chk("basic_step", 32'(dispatch_step), 32'(k));
            if (k == 4) chk("basic_vector", 32'(vector_addr), 32'h50);
            pulse();
        end
        chk("basic_done", 32'(dispatch_active), 32'd0);
        chk("basic_if_clear", 32'(if_rd_data), 32'h0E0);
        irq_req = 5'b00100; pulse();
        instr_boundary = 1; pulse();
        chk("basic_ime_cleared", 32'(dispatch_active), 32'd0);

        // Priority: VBlank beats the others
        if_wr_en = 1; if_wr_data = 5'b10011; ie_wr_en = 1; ie_wr_data = 8'h1F; reti_exec = 1; pulse();
        instr_boundary = 1; pulse();
        repeat (4) pulse();
        chk("prio_vector", 32'(vector_addr), 32'h40);
        pulse();
        chk("prio_if_after", 32'(if_rd_data), 32'h0F2);

        // EI delay
        if_wr_en = 1; if_wr_data = 5'b00001; ei_exec = 1; pulse();
        instr_boundary = 1; pulse();
        chk("ei_boundary1", 32'(dispatch_active), 32'd0);
        pulse();
        instr_boundary = 1; pulse();
        chk("ei_boundary2", 32'(dispatch_active), 32'd1);
        repeat (5) pulse();
        chk("ei_if_after", 32'(if_rd_data), 32'h0E0);

        // Cancellation by IE overwrite during step 2
        ie_wr_en = 1; ie_wr_data = 8'h01; if_wr_en = 1; if_wr_data = 5'b00001; reti_exec = 1; pulse();
        instr_boundary = 1; pulse();
        pulse(); pulse();
        chk("cancel_step2", 32'(dispatch_step), 32'd2);
        ie_wr_en = 1; ie_wr_data = 8'h00; pulse();
        pulse();
        chk("cancel_vector", 32'(vector_addr), 32'h00);
        pulse();
        chk("cancel_if", 32'(if_rd_data), 32'h0E1);
        chk("cancel_done", 32'(dispatch_active), 32'd0);

        // HALT with nothing pending, woken without dispatch
        ie_wr_en = 1; ie_wr_data = 8'h01; if_wr_en = 1; if_wr_data = 5'b00000; di_exec = 1; pulse();
        halt_exec = 1; instr_boundary = 1; pulse();
        chk("halt_enter", 32'(halted), 32'd1);
        pulse();
        chk("halt_hold", 32'(halted), 32'd1);
        irq_req = 5'b00001; pulse();
        chk("halt_irq_edge", 32'(halted), 32'd1);
        pulse();
        chk("halt_exit", 32'(halted), 32'd0);
        chk("halt_exit_nodisp", 32'(dispatch_active), 32'd0);
        pulse();
        chk("halt_exit_nodisp2", 32'(dispatch_active), 32'd0);

        // HALT bug
        halt_exec = 1; instr_boundary = 1; pulse();
        chk("haltbug_pulse", 32'(halt_bug), 32'd1);
        chk("haltbug_nohalt", 32'(halted), 32'd0);
        pulse();
        chk("haltbug_once", 32'(halt_bug), 32'd0);
        chk("haltbug_nohalt2", 32'(halted), 32'd0);

        // New request collides with acknowledge clear
        reti_exec = 1; pulse();
        instr_boundary = 1; pulse();
        repeat (4) pulse();
        chk("collide_vector", 32'(vector_addr), 32'h40);
        irq_req = 5'b00001; pulse();
        chk("collide_if", 32'(if_rd_data), 32'h0E1);

        // Reset in the middle of a dispatch
        reti_exec = 1; pulse();
        instr_boundary = 1; pulse();
        pulse(); pulse();
        chk("rst_mid_step", 32'(dispatch_step), 32'd2);
        reset_n = 0; pulse();
        chk_reset_outputs("rst_mid");
        reset_n = 1;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            clr();
            reset_n = ($urandom_range(0, 599) != 0);
            for (int b = 0; b < 5; b++) irq_req[b] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 24) == 0) begin if_wr_en = 1; if_wr_data = 5'($urandom); end
            if ($urandom_range(0, 24) == 0) begin ie_wr_en = 1; ie_wr_data = 8'($urandom); end
            if (m_mode == 2) begin
                instr_boundary = 1'($urandom_range(0, 1));
            end else if (m_mode == 0) begin
                instr_boundary = ($urandom_range(0, 2) == 0);
                if (instr_boundary) begin
                    halt_exec = ($urandom_range(0, 4) == 0);
                end else begin
                    case ($urandom_range(0, 9))
                        0: ei_exec = 1;
                        1: reti_exec = 1;
                        2: di_exec = 1;
                        3: begin di_exec = 1; ei_exec = 1; end
                        default: ;
                    endcase
                end
            end
            next();
        end
        clr();
        reset_n = 1;
        repeat (3) pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
